// File: rtl/jts16_gfx_arb.sv
// jts16_gfx_arb: shares one SDRAM read channel among the six video-layer ROM
// fetch ports (char, map1, scr1, map2, scr2, obj).
//   clk, rst_n        : clock, asynchronous active-low reset
//   <x>_cs/<x>_addr   : client read request (level) and word address
//   <x>_ok/<x>_data   : cached data valid for the current address, cached data
//   sdram_req/addr    : read request to the controller, held until sdram_ack
//   sdram_ack/dst/data: request accepted, one-cycle data strobe, read data
// Each client keeps a one-entry cache (address, data, valid), so repeated reads
// of the same address cost nothing. Misses are served round-robin.
module jts16_gfx_arb #(
  parameter logic [21:0] CHAR_OFFSET = 22'h00000,
  parameter logic [21:0] MAP1_OFFSET = 22'h10000,
  parameter logic [21:0] SCR1_OFFSET = 22'h20000,
  parameter logic [21:0] MAP2_OFFSET = 22'h10000,
  parameter logic [21:0] SCR2_OFFSET = 22'h20000,
  parameter logic [21:0] OBJ_OFFSET  = 22'h80000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        char_cs,
  input  logic        map1_cs,
  input  logic        scr1_cs,
  input  logic        map2_cs,
  input  logic        scr2_cs,
  input  logic        obj_cs,
  input  logic [12:0] char_addr,
  input  logic [13:0] map1_addr,
  input  logic [16:0] scr1_addr,
  input  logic [13:0] map2_addr,
  input  logic [16:0] scr2_addr,
  input  logic [17:0] obj_addr,
  output logic        char_ok,
  output logic        map1_ok,
  output logic        scr1_ok,
  output logic        map2_ok,
  output logic        scr2_ok,
  output logic        obj_ok,
  output logic [31:0] char_data,
  output logic [15:0] map1_data,
  output logic [31:0] scr1_data,
  output logic [15:0] map2_data,
  output logic [31:0] scr2_data,
  output logic [15:0] obj_data,
  output logic        sdram_req,
  output logic [21:0] sdram_addr,
  input  logic        sdram_ack,
  input  logic        sdram_dst,
  input  logic [31:0] sdram_data
);
  localparam int N = 6;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} st_t;

  // client index order: 0 char, 1 map1, 2 scr1, 3 map2, 4 scr2, 5 obj
  logic [N-1:0]        cs;
  logic [N-1:0][17:0]  addr;
  logic [N-1:0][21:0]  offs;

  assign cs   = {obj_cs, scr2_cs, map2_cs, scr1_cs, map1_cs, char_cs};
  assign addr[0] = {5'd0, char_addr};
  assign addr[1] = {4'd0, map1_addr};
  assign addr[2] = {1'd0, scr1_addr};
  assign addr[3] = {4'd0, map2_addr};
  assign addr[4] = {1'd0, scr2_addr};
  assign addr[5] = obj_addr;
  assign offs = {OBJ_OFFSET, SCR2_OFFSET, MAP2_OFFSET, SCR1_OFFSET, MAP1_OFFSET, CHAR_OFFSET};

  st_t                st_q;
  logic [N-1:0]       valid_q;
  logic [N-1:0][17:0] la_q;     // cached address per client
  logic [N-1:0][31:0] ld_q;     // cached data per client
  logic [2:0]         gnt_q;    // client owning the transaction in flight
  logic [2:0]         last_q;   // last client served, round-robin pointer
  logic [17:0]        fa_q;     // client address latched at grant
  logic               req_q;
  logic [21:0]        sa_q;

  logic [N-1:0] hit, pend;
  logic [2:0]   gnt_d;
  logic         any_d;
  logic [3:0]   rr_s;
  logic         fill_d;

  always_comb begin
    for (int i = 0; i < N; i++) hit[i] = valid_q[i] & (addr[i] == la_q[i]);
  end
  assign pend = cs & ~hit;

  // Scan from last_q+N down to last_q+1 so the nearest pending client after
  // the previous grant is the one left in gnt_d.
  always_comb begin
    gnt_d = last_q;
    any_d = 1'b0;
    rr_s  = 4'd0;
    for (int k = N; k >= 1; k--) begin
      rr_s = {1'b0, last_q} + 4'(k);
      if (rr_s >= 4'(N)) rr_s = rr_s - 4'(N);
      if (pend[rr_s[2:0]]) begin
        gnt_d = rr_s[2:0];
        any_d = 1'b1;
      end
    end
  end

  // dst is only meaningful once the request was accepted (same-cycle ack ok)
  assign fill_d = ((st_q == REQ) & sdram_ack & sdram_dst) | ((st_q == WAIT) & sdram_dst);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= IDLE;
      valid_q <= '0;
      la_q    <= '0;
      ld_q    <= '0;
      gnt_q   <= 3'd0;
      last_q  <= 3'd5;
      fa_q    <= '0;
      req_q   <= 1'b0;
      sa_q    <= '0;
    end else begin
      case (st_q)
        IDLE: if (any_d) begin
          gnt_q          <= gnt_d;
          fa_q           <= addr[gnt_d];
          sa_q           <= offs[gnt_d] + {4'd0, addr[gnt_d]};
          req_q          <= 1'b1;
          // entry is about to be overwritten: never let it hit in between
          valid_q[gnt_d] <= 1'b0;
          st_q           <= REQ;
        end
        REQ: if (sdram_ack) begin
          req_q <= 1'b0;
          st_q  <= sdram_dst ? IDLE : WAIT;
        end
        WAIT: if (sdram_dst) st_q <= IDLE;
        default: st_q <= IDLE;
      endcase
      if (fill_d) begin
        valid_q[gnt_q] <= 1'b1;
        la_q[gnt_q]    <= fa_q;
        ld_q[gnt_q]    <= sdram_data;
        last_q         <= gnt_q;
      end
    end
  end

  assign {obj_ok, scr2_ok, map2_ok, scr1_ok, map1_ok, char_ok} = hit & cs;
  assign char_data  = ld_q[0];
  assign map1_data  = ld_q[1][15:0];
  assign scr1_data  = ld_q[2];
  assign map2_data  = ld_q[3][15:0];
  assign scr2_data  = ld_q[4];
  assign obj_data   = ld_q[5][15:0];
  assign sdram_req  = req_q;
  assign sdram_addr = sa_q;

  logic unused_hi;
  assign unused_hi = ^{ld_q[1][31:16], ld_q[3][31:16], ld_q[5][31:16]};
endmodule

// File: tb/tb_jts16_gfx_arb.sv
// Bench for jts16_gfx_arb: randomized client traffic and a randomized SDRAM
// controller, checked every cycle against a transaction-level model of the
// per-client caches and the round-robin service order.
module tb_jts16_gfx_arb;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  localparam logic [17:0] MSK [6] = '{18'h01fff, 18'h03fff, 18'h1ffff, 18'h03fff, 18'h1ffff, 18'h3ffff};
  localparam logic [21:0] OFF [6] = '{22'h00000, 22'h10000, 22'h20000, 22'h10000, 22'h20000, 22'h80000};

  logic [5:0]  cs;
  logic [17:0] ca [6];
  logic [5:0]  ok;
  logic [31:0] dat [6];
  logic [31:0] char_data, scr1_data, scr2_data;
  logic [15:0] map1_data, map2_data, obj_data;
  logic        sdram_req, sdram_ack, sdram_dst;
  logic [21:0] sdram_addr;
  logic [31:0] sdram_data;

  jts16_gfx_arb dut (
    .clk(clk), .rst_n(rst_n),
    .char_cs(cs[0]), .map1_cs(cs[1]), .scr1_cs(cs[2]),
    .map2_cs(cs[3]), .scr2_cs(cs[4]), .obj_cs(cs[5]),
    .char_addr(ca[0][12:0]), .map1_addr(ca[1][13:0]), .scr1_addr(ca[2][16:0]),
    .map2_addr(ca[3][13:0]), .scr2_addr(ca[4][16:0]), .obj_addr(ca[5]),
    .char_ok(ok[0]), .map1_ok(ok[1]), .scr1_ok(ok[2]),
    .map2_ok(ok[3]), .scr2_ok(ok[4]), .obj_ok(ok[5]),
    .char_data(char_data), .map1_data(map1_data), .scr1_data(scr1_data),
    .map2_data(map2_data), .scr2_data(scr2_data), .obj_data(obj_data),
    .sdram_req(sdram_req), .sdram_addr(sdram_addr),
    .sdram_ack(sdram_ack), .sdram_dst(sdram_dst), .sdram_data(sdram_data)
  );

  assign dat[0] = char_data;
  assign dat[1] = {16'h0, map1_data};
  assign dat[2] = scr1_data;
  assign dat[3] = {16'h0, map2_data};
  assign dat[4] = scr2_data;
  assign dat[5] = {16'h0, obj_data};

  int n_tot = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // reference model: cache contents plus the one transaction in flight
  bit          m_v [6];
  logic [17:0] m_a [6];
  logic [31:0] m_d [6];
  int          m_last, m_g, m_ph;   // m_ph: 0 none, 1 requesting, 2 accepted
  logic [17:0] m_la;

  // controller model
  int ack_d = 0, dst_d = 1, c_st = 0, c_n = 0, n_ack = 0, n_reqc = 0;
  bit rnd_dly = 0;
  logic [31:0] c_last;
  logic [21:0] alog [$];

  task automatic m_reset();
    for (int i = 0; i < 6; i++) begin m_v[i] = 0; m_a[i] = '0; m_d[i] = '0; end
    m_last = 5; m_ph = 0; m_g = 0; m_la = '0;
    c_st = 0; c_n = 0;
  endtask

  task automatic new_dly();
    if (rnd_dly) begin ack_d = $urandom_range(0, 3); dst_d = $urandom_range(0, 4); end
  endtask

  // check at negedge, advance model, then drive controller after posedge
  task automatic cycle();
    int j;
    bit hit;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      hit = m_v[i] && (ca[i] == m_a[i]);
      chk($sformatf("ok%0d", i), ok[i], hit && cs[i]);
      chk($sformatf("data%0d", i), dat[i], (i % 2 == 1) ? {16'h0, m_d[i][15:0]} : m_d[i]);
    end
    chk("req", sdram_req, m_ph == 1);
    if (m_ph == 1) chk("addr", sdram_addr, 22'(OFF[m_g] + {4'b0, m_la}));
    if (sdram_req) n_reqc++;
    case (m_ph)
      0: for (int k = 1; k <= 6; k++) begin
        j = (m_last + k) % 6;
        if (cs[j] && !(m_v[j] && ca[j] == m_a[j])) begin
          m_g = j; m_la = ca[j]; m_v[j] = 0; m_ph = 1;
          break;
        end
      end
      1: if (sdram_ack) m_ph = sdram_dst ? 3 : 2;
      2: if (sdram_dst) m_ph = 3;
      default: ;
    endcase
    if (m_ph == 3) begin
      m_a[m_g] = m_la; m_d[m_g] = sdram_data; m_v[m_g] = 1; m_last = m_g; m_ph = 0;
    end
    @(posedge clk); #1;
    sdram_ack = 0; sdram_dst = 0; sdram_data = $urandom;
    if (c_st == 0) begin
      if (sdram_req) begin
        if (c_n >= ack_d) begin
          sdram_ack = 1; n_ack++; c_n = 0; alog.push_back(sdram_addr);
          if (dst_d == 0) begin sdram_dst = 1; c_last = sdram_data; new_dly(); end
          else c_st = 1;
        end else begin
          c_n++;
          if ($urandom_range(0, 7) == 0) sdram_dst = 1;   // stray strobe, must be ignored
        end
      end else if ($urandom_range(0, 7) == 0) sdram_dst = 1;
    end else begin
      if (c_n + 1 >= dst_d) begin
        sdram_dst = 1; c_last = sdram_data; c_st = 0; c_n = 0; new_dly();
      end else c_n++;
    end
  endtask

  initial begin
    int r0, a0, n;
    bit hit_w;
    cs = '0;
    for (int i = 0; i < 6; i++) ca[i] = '0;
    sdram_ack = 0; sdram_dst = 0; sdram_data = '0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", sdram_req, 0);
    chk("rst_addr", sdram_addr, 0);
    chk("rst_ok", ok, 0);
    rst_n = 1;

    // single miss: ack 2 cycles after request, dst 3 cycles after ack
    ack_d = 2; dst_d = 3;
    cs[0] = 1; ca[0] = 18'h5;
    repeat (14) cycle();
    chk("miss_ok", ok[0], 1);
    chk("miss_data", char_data, c_last);
    chk("miss_addr", alog[alog.size()-1], 22'h00005);

    // same address after cs toggle: hit, no SDRAM request
    cs[0] = 0; cycle();
    cs[0] = 1; r0 = n_reqc;
    #1 chk("hit_now", ok[0], 1);
    repeat (4) cycle();
    chk("hit_noreq", n_reqc - r0, 0);

    // reset while requesting; afterwards all six miss and are served in order
    ack_d = 6; cs[0] = 1; ca[0] = 18'h9;
    hit_w = 0;
    for (int t = 0; t < 20 && !hit_w; t++) begin cycle(); hit_w = sdram_req; end
    chk("to_req", hit_w, 1);
    #2 rst_n = 0;
    #1 chk("arst_req", sdram_req, 0);
    chk("arst_ok", ok, 0);
    for (int i = 0; i < 6; i++) chk($sformatf("arst_data%0d", i), dat[i], 0);
    m_reset();
    sdram_ack = 0; sdram_dst = 0;
    cs = 6'h3f;
    ca[0] = 18'h11; ca[1] = 18'h22; ca[2] = 18'h333; ca[3] = 18'h44; ca[4] = 18'h555; ca[5] = 18'h666;
    ack_d = 0; dst_d = 1;
    a0 = n_ack; alog.delete();
    @(posedge clk); #1 rst_n = 1;
    repeat (60) cycle();
    chk("six_txn", n_ack - a0, 6);
    for (int i = 0; i < 6 && i < alog.size(); i++)
      chk($sformatf("six_ord%0d", i), alog[i], 22'(OFF[i] + {4'b0, ca[i]}));
    chk("six_ok", ok, 6'h3f);

    // obj moves its address while its fetch is waiting for data
    cs = 6'h20; ca[5] = 18'h10; dst_d = 3;
    hit_w = 0;
    for (int t = 0; t < 30 && !hit_w; t++) begin cycle(); hit_w = (m_ph == 2); end
    chk("to_wait", hit_w, 1);
    n = alog.size();
    ca[5] = 18'h20;
    repeat (30) cycle();
    chk("obj_2nd_n", alog.size(), n + 1);
    if (alog.size() > n) chk("obj_2nd", alog[n], 22'h80020);
    chk("obj_ok", ok[5], 1);

    // random traffic with random controller timing
    rnd_dly = 1; new_dly();
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < 6; i++) begin
        if ($urandom_range(0, 9) == 0) cs[i] = ~cs[i];
        if ($urandom_range(0, 5) == 0)
          ca[i] = ($urandom_range(0, 7) == 0) ? (18'($urandom) & MSK[i]) : 18'($urandom_range(0, 3));
      end
      cycle();
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
